// File: rtl/store_queue.sv
// store_queue: a DEPTH-entry FIFO of pending stores.
// Stores go in at the tail and leave from the head toward memory in strict
// order. Loads can be checked combinationally against the pending entries at
// word granularity. Stores whose byte enables are all zero are accepted and
// then dropped.
module store_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,

   // store request side
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [3:0]  st_we_data,
   input  logic [3:0]  st_we_inst,

   // memory side (head of queue)
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic [3:0]  mem_we_data,
   output logic [3:0]  mem_we_inst,

   // load hazard check
   input  logic        ld_check_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hazard,

   output logic [4:0]  count
);

   localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] FULL_CNT = 5'(DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [4:0]       count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;

   // Entry payload: word address, lane-formatted data, both enable masks.
   logic [29:0] addr_q    [DEPTH];
   logic [31:0] data_q    [DEPTH];
   logic [3:0]  we_data_q [DEPTH];
   logic [3:0]  we_inst_q [DEPTH];

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   logic             accept;       // store handshake completes this edge
   logic             enq;          // accepted store carries at least one enable
   logic             deq;          // head entry leaves this edge
   logic [DEPTH-1:0] head_onehot;
   logic [DEPTH-1:0] live_mask;    // entries that still count for hazards

   // Full queue never accepts, even when the head drains this cycle.
   assign st_ready  = (count_q != FULL_CNT);
   assign accept    = st_valid & st_ready;
   assign enq       = accept & ((st_we_data | st_we_inst) != 4'b0000);

   assign mem_valid = (count_q != 5'd0);
   assign deq       = mem_valid & mem_ready;

   assign count     = count_q;

   // Entry leaving this cycle is no longer a hazard for the load.
   assign head_onehot = DEPTH'(1) << head_q;
   assign live_mask   = deq ? (valid_q & ~head_onehot) : valid_q;

   // Byte-offset bits of both addresses play no part at word granularity.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

   // ------------------------------------------------------------------
   // Next-state for pointers, occupancy and valid bits
   // ------------------------------------------------------------------
   // Compute pointer, count and valid-bit updates from enq/deq.
   always_comb begin
      // NOTE: every output of a combinational block gets a default before any
      // branch; a path that leaves one unassigned infers a latch.
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      valid_d = valid_q;

      // Enqueue and dequeue never touch the same slot: a full queue cannot
      // enqueue, and otherwise the tail is never the head of a live entry.
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + PTR_W'(1);
      end

      if (deq) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end

      unique case ({enq, deq})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase
   end

   // Control registers; reset drops every pending entry at once.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Payload write at the tail slot on enqueue.
   always_ff @(posedge clk) begin
      // NOTE: the payload array has no reset; valid bits and count alone
      // decide whether a slot means anything, so stale contents are harmless.
      if (enq) begin
         addr_q[tail_q]    <= st_addr[31:2];
         data_q[tail_q]    <= st_data;
         we_data_q[tail_q] <= st_we_data;
         we_inst_q[tail_q] <= st_we_inst;
      end
   end

   // ------------------------------------------------------------------
   // Memory-side outputs
   // ------------------------------------------------------------------
   // Present the head entry; everything reads zero when the queue is empty.
   always_comb begin
      mem_addr    = 32'h0;
      mem_data    = 32'h0;
      mem_we_data = 4'b0000;
      mem_we_inst = 4'b0000;
      if (mem_valid) begin
         mem_addr    = {addr_q[head_q], 2'b00};
         mem_data    = data_q[head_q];
         mem_we_data = we_data_q[head_q];
         mem_we_inst = we_inst_q[head_q];
      end
   end

   // ------------------------------------------------------------------
   // Load hazard check
   // ------------------------------------------------------------------
   // Flag a load whose word matches any live pending store.
   always_comb begin
      ld_hazard = 1'b0;
      if (ld_check_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (live_mask[i] && (addr_q[i] == ld_addr[31:2])) begin
               ld_hazard = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed checks of store_queue with DEPTH=4.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising edge where state moves.
module tb_store_queue;

   logic        clk;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_we_data;
   logic [3:0]  st_we_inst;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_we_data;
   logic [3:0]  mem_we_inst;
   logic        ld_check_valid;
   logic [31:0] ld_addr;
   logic        ld_hazard;
   logic [4:0]  count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q [$];

   store_queue #(.DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .st_valid       (st_valid),
      .st_ready       (st_ready),
      .st_addr        (st_addr),
      .st_data        (st_data),
      .st_we_data     (st_we_data),
      .st_we_inst     (st_we_inst),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_we_data    (mem_we_data),
      .mem_we_inst    (mem_we_inst),
      .ld_check_valid (ld_check_valid),
      .ld_addr        (ld_addr),
      .ld_hazard      (ld_hazard),
      .count          (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case anything stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One rising edge, then land on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] wd, input logic [3:0] wi);
      st_valid   = 1'b1;
      st_addr    = a;
      st_data    = d;
      st_we_data = wd;
      st_we_inst = wi;
   endtask

   initial begin
      rst            = 1'b1;
      st_valid       = 1'b0;
      st_addr        = 32'h0;
      st_data        = 32'h0;
      st_we_data     = 4'h0;
      st_we_inst     = 4'h0;
      mem_ready      = 1'b0;
      ld_check_valid = 1'b1;
      ld_addr        = 32'h0;

      // ---------------- reset state ----------------
      @(negedge clk);
      #1;
      check("rst_count",     32'(count),     32'd0);
      check("rst_st_ready",  32'(st_ready),  32'd1);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_mem_addr",  mem_addr,       32'h0);
      check("rst_mem_data",  mem_data,       32'h0);
      check("rst_hazard",    32'(ld_hazard), 32'd0);

      // ---------------- scenario 1: single store, first edge after reset ----------------
      rst            = 1'b0;
      ld_check_valid = 1'b0;
      mem_ready      = 1'b1;
      drive_store(32'h1000_0004, 32'hDEAD_BEEF, 4'b1111, 4'b0000);
      #1;
      check("s1_st_ready", 32'(st_ready), 32'd1);
      step();
      st_valid = 1'b0;
      #1;
      check("s1_mem_valid", 32'(mem_valid),   32'd1);
      check("s1_mem_addr",  mem_addr,         32'h1000_0004);
      check("s1_mem_data",  mem_data,         32'hDEAD_BEEF);
      check("s1_we_data",   32'(mem_we_data), 32'hF);
      check("s1_count1",    32'(count),       32'd1);
      step();
      #1;
      check("s1_count0",    32'(count),     32'd0);
      check("s1_drained",   32'(mem_valid), 32'd0);
      check("s1_data_zero", mem_data,       32'h0);

      // ---------------- scenario 3: zero-mask store is dropped ----------------
      drive_store(32'h1000_0020, 32'h1234_5678, 4'b0000, 4'b0000);
      #1;
      check("s3_st_ready", 32'(st_ready), 32'd1);
      step();
      st_valid = 1'b0;
      #1;
      check("s3_count",     32'(count),     32'd0);
      check("s3_mem_valid", 32'(mem_valid), 32'd0);

      // ---------------- scenario 2: fill, blocked 5th, ordered drain ----------------
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) drive_store(32'h0000_0100 + 32'(4 * i), 32'hA0 + 32'(i), 4'b0000, 4'b0011);
         else        drive_store(32'h0000_0100 + 32'(4 * i), 32'hA0 + 32'(i), 4'b1111, 4'b0000);
         step();
      end
      drive_store(32'h0000_0200, 32'h0000_0BAD, 4'b1111, 4'b0000);
      #1;
      check("s2_full_count", 32'(count),    32'd4);
      check("s2_full_ready", 32'(st_ready), 32'd0);
      check("s2_head_hold",  mem_data,      32'hA0);
      step();
      #1;
      check("s2_5th_rejected", 32'(count), 32'd4);
      check("s2_head_stable",  mem_data,   32'hA0);
      check("s2_addr_stable",  mem_addr,   32'h0000_0100);
      st_valid  = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("s2_drain_data%0d", i), mem_data,     32'hA0 + 32'(i));
         check($sformatf("s2_drain_addr%0d", i), mem_addr,     32'h0000_0100 + 32'(4 * i));
         check($sformatf("s2_drain_cnt%0d",  i), 32'(count),   32'(4 - i));
         if (i == 2) check("s2_we_inst", 32'(mem_we_inst), 32'h3);
         step();
      end
      #1;
      check("s2_empty", 32'(count), 32'd0);

      // ---------------- scenario 4: load hazard ----------------
      mem_ready = 1'b0;
      drive_store(32'h1000_0008, 32'h0000_0055, 4'b0001, 4'b0000);
      step();
      st_valid       = 1'b0;
      ld_check_valid = 1'b1;
      ld_addr        = 32'h1000_000B;
      #1;
      check("s4_hit_same_word", 32'(ld_hazard), 32'd1);
      ld_addr = 32'h1000_000C;
      #1;
      check("s4_next_word", 32'(ld_hazard), 32'd0);
      ld_addr        = 32'h1000_000B;
      ld_check_valid = 1'b0;
      #1;
      check("s4_check_off", 32'(ld_hazard), 32'd0);
      ld_check_valid = 1'b1;
      mem_ready      = 1'b1;
      #1;
      check("s4_dequeuing_excluded", 32'(ld_hazard), 32'd0);
      step();
      #1;
      check("s4_after_drain", 32'(ld_hazard), 32'd0);

      // incoming store is not visible to the hazard check until enqueued
      mem_ready = 1'b0;
      drive_store(32'h2000_0000, 32'h0000_0077, 4'b1111, 4'b0000);
      ld_addr = 32'h2000_0002;
      #1;
      check("s4_incoming_excluded", 32'(ld_hazard), 32'd0);
      step();
      st_valid = 1'b0;
      #1;
      check("s4_enqueued_hit", 32'(ld_hazard), 32'd1);
      ld_check_valid = 1'b0;

      // ---------------- scenario 5: steady enqueue+dequeue at count=2 ----------------
      drive_store(32'h2000_0004, 32'h0000_0078, 4'b1111, 4'b0000);
      step();
      exp_q = {32'h77, 32'h78};
      for (int k = 0; k < 10; k++) begin
         drive_store(32'h3000_0000 + 32'(4 * k), 32'h100 + 32'(k), 4'b1111, 4'b0000);
         mem_ready = 1'b1;
         #1;
         check($sformatf("s5_data%0d", k),  mem_data,   exp_q[0]);
         check($sformatf("s5_count%0d", k), 32'(count), 32'd2);
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(32'h100 + 32'(k));
      end
      st_valid  = 1'b0;
      mem_ready = 1'b0;
      #1;
      check("s5_final_count", 32'(count), 32'd2);
      check("s5_final_head",  mem_data,   exp_q[0]);

      // ---------------- scenario 6: asynchronous reset mid-operation ----------------
      drive_store(32'h4000_0000, 32'h0000_01AA, 4'b1111, 4'b0000);
      step();
      st_valid = 1'b0;
      #1;
      check("s6_pre_count", 32'(count), 32'd3);
      #1;
      rst = 1'b1;
      #1;
      check("s6_async_count",     32'(count),     32'd0);
      check("s6_async_mem_valid", 32'(mem_valid), 32'd0);
      check("s6_async_mem_data",  mem_data,       32'h0);
      check("s6_async_st_ready",  32'(st_ready),  32'd1);
      #1;
      rst = 1'b0;
      exp_q.delete();
      drive_store(32'h5000_0010, 32'h00C0_FFEE, 4'b0001, 4'b0000);
      step();
      st_valid = 1'b0;
      #1;
      check("s6_new_count",   32'(count),       32'd1);
      check("s6_new_data",    mem_data,         32'h00C0_FFEE);
      check("s6_new_addr",    mem_addr,         32'h5000_0010);
      check("s6_new_we_data", 32'(mem_we_data), 32'h1);

      // ---------------- count=1 simultaneous enqueue and dequeue ----------------
      drive_store(32'h6000_0000, 32'h0000_D00D, 4'b0000, 4'b1111);
      mem_ready = 1'b1;
      #1;
      check("c1_old_head", mem_data, 32'h00C0_FFEE);
      step();
      st_valid = 1'b0;
      #1;
      check("c1_count",    32'(count),       32'd1);
      check("c1_new_head", mem_data,         32'h0000_D00D);
      check("c1_we_inst",  32'(mem_we_inst), 32'hF);
      check("c1_we_data",  32'(mem_we_data), 32'h0);
      step();
      #1;
      check("c1_empty",     32'(count),     32'd0);
      check("c1_mem_valid", 32'(mem_valid), 32'd0);
      check("c1_mem_addr",  mem_addr,       32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; it is asynchronous and active-high.
REQ-004 SHALL have port st_valid  input  1  a store request is presented.
REQ-005 SHALL have port st_ready  output  1  the queue can accept a store request.
REQ-006 SHALL have port st_addr  input  32  store byte address.
REQ-007 SHALL have port st_data  input  32  store data, already lane-formatted.
REQ-008 SHALL have port st_we_data  input  4  byte enables for data memory.
REQ-009 SHALL have port st_we_inst  input  4  byte enables for instruction memory.
REQ-010 SHALL have port mem_valid  output  1  the head entry is presented to memory.
REQ-011 SHALL have port mem_ready  input  1  memory accepts the head entry.
REQ-012 SHALL have port mem_addr  output  32  head word address, equal to {addr[31:2], 2'b00}.
REQ-013 SHALL have port mem_data  output  32  head store data.
REQ-014 SHALL have ports mem_we_data and mem_we_inst  output  4 each  head byte enables.
REQ-015 SHALL have port ld_check_valid  input  1  a load address is presented for a hazard check.
REQ-016 SHALL have port ld_addr  input  32  load byte address.
REQ-017 SHALL have port ld_hazard  output  1  the load word overlaps a pending store.
REQ-018 SHALL have port count  output  5  number of occupied entries.

Function
REQ-019 SHALL accept a store when st_valid and st_ready are both 1 at a rising clk edge.
REQ-020 SHALL drive st_ready = (count != DEPTH); no bypass is provided when the queue is full, even if a dequeue occurs in the same cycle.
REQ-021 SHALL discard, without enqueuing, an accepted store whose st_we_data and st_we_inst are both 4'b0000.
REQ-022 SHALL store per entry: addr[31:2], data, we_data, and we_inst; the entry is written at the tail pointer, and the tail pointer then increments modulo DEPTH.
REQ-023 SHALL drive mem_valid = (count != 0), with the mem_* outputs taken combinationally from the head entry.
REQ-024 SHALL dequeue when mem_valid and mem_ready are both 1 at an edge; the head pointer then increments modulo DEPTH.
REQ-025 SHALL hold mem_addr, mem_data, and both enables stable while mem_valid=1 and mem_ready=0.
REQ-026 SHALL, on a simultaneous enqueue and dequeue, update both pointers and leave count unchanged; this includes the case count=1, where the head is replaced by the new entry next cycle.
REQ-027 SHALL drive mem_valid=0 and all mem_* outputs to 0 when the queue is empty; an incoming store is never bypassed combinationally to mem_*.
REQ-028 SHALL deliver stores to memory in strict FIFO order.
REQ-029 SHALL maintain exactly one valid bit per entry; ld_hazard is asserted when ld_check_valid=1 and any valid entry has addr[31:2] == ld_addr[31:2]. The check is combinational, and ld_hazard is 0 when ld_check_valid=0.
REQ-030 SHALL exclude from the hazard check both the store being accepted and the entry being dequeued in the same cycle.
REQ-031 SHALL wrap the pointers correctly across the DEPTH boundary without corrupting entries.
REQ-032 SHALL keep count within the range 0..DEPTH at all times; count is registered.

Reset
REQ-033 SHALL, while rst=1, asynchronously clear both pointers, count, and all valid bits; during reset st_ready=1, mem_valid=0, mem_* outputs are 0, and ld_hazard=0.
REQ-034 SHALL discard all pending entries on a reset asserted mid-operation; no partial drain occurs after reset.
REQ-035 SHALL accept a new store on the first rising edge after rst deasserts.

Verification
REQ-036 Scenario 1: after reset, sw to 0x10000004 with data 0xDEADBEEF and we_data 4'b1111, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x10000004, mem_data=0xDEADBEEF; one cycle later count returns to 0.
REQ-037 Scenario 2: with mem_ready=0, enqueue 4 stores -> st_ready=0 and count=4; the 5th st_valid is not accepted; raising mem_ready drains the stores in order, 1 per cycle.
REQ-038 Scenario 3: store with both masks 0 and st_valid=1 -> st_ready=1, count stays 0, mem_valid stays 0.
REQ-039 Scenario 4: pending store at 0x10000008 with ld_check_valid=1 -> ld_addr=0x1000000B gives ld_hazard=1; ld_addr=0x1000000C gives ld_hazard=0; after the store drains, ld_hazard=0.
REQ-040 Scenario 5: count=2 with simultaneous enqueue and dequeue for 10 cycles -> count stays 2; the pointers wrap; the mem_data sequence matches the enqueue order.
REQ-041 Scenario 6: rst pulsed asynchronously between edges while count=3 -> count=0 and mem_valid=0 immediately; a new store is accepted at the first edge after release.
